// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit start qualification, centre sampling.
// Define UART_RX_PARITY_EN for 8E1 framing with a parity_err strobe.
module uart_rx #(
    parameter int BAUD_RATE   = 115_200,
    parameter int CLOCK_SPEED = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rx_valid,
    output logic       frame_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int BAUD_WIDTH = CLOCK_SPEED / BAUD_RATE;
    localparam int HALF_WIDTH = BAUD_WIDTH / 2;
    localparam int CW         = $clog2(BAUD_WIDTH);

    localparam logic [CW-1:0] CNT_HALF = CW'(HALF_WIDTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(BAUD_WIDTH - 1);

`ifdef UART_RX_PARITY_EN
    localparam int NS = 5;
    localparam logic [NS-1:0] PARITY = 5'b01000;
    localparam logic [NS-1:0] STOP   = 5'b10000;
`else
    localparam int NS = 4;
    localparam logic [NS-1:0] STOP   = 4'b1000;
`endif
    localparam logic [NS-1:0] IDLE  = NS'(1);
    localparam logic [NS-1:0] START = NS'(2);
    localparam logic [NS-1:0] DATA  = NS'(4);

    logic [NS-1:0] state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          rx_meta, rx_s;
    // Cleared by a framing error so a held-low line (break) is reported only once.
    logic          armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bit;
    logic par_bad;
    assign par_bad = (^shreg) ^ par_bit;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bit_idx   <= 3'd0;
            shreg     <= 8'h00;
            data      <= 8'h00;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            armed     <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bit    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (!armed) begin
                        if (rx_s) armed <= 1'b1;
                    end else if (!rx_s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == CNT_HALF) begin
                        cnt <= '0;
                        if (rx_s) begin
                            state <= IDLE;
                        end else begin
                            state   <= DATA;
                            bit_idx <= 3'd0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_FULL) begin
                        cnt     <= '0;
                        par_bit <= rx_s;
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
`endif
                STOP: begin
                    // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                    if (cnt == CNT_FULL) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (!rx_s) begin
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                        end
`ifdef UART_RX_PARITY_EN
                        parity_err <= par_bad;
                        if (rx_s && !par_bad) begin
                            data     <= shreg;
                            rx_valid <= 1'b1;
                        end
`else
                        if (rx_s) begin
                            data     <= shreg;
                            rx_valid <= 1'b1;
                        end
`endif
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's uart_tx.
- Oversamples the asynchronous serial line `rx` with the system clock, qualifies the start bit at mid-bit, and samples 8 data bits LSB-first at bit centres.
- Checks the stop bit and presents each received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the byte-level consumer (FIFO or command parser).

Parameters:
- BAUD_RATE, 115_200, serial bit rate in bits/s.
- CLOCK_SPEED, 50_000_000, clk frequency in Hz.
- BAUD_WIDTH (derived, localparam), CLOCK_SPEED/BAUD_RATE (integer division, 434 at defaults), clocks per bit.
- HALF_WIDTH (derived, localparam), BAUD_WIDTH/2 (217 at defaults), clocks to start-bit centre.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- data  output  8  last correctly framed byte; holds until the next good frame.
- rx_valid  output  1  one-cycle pulse: a new byte is on `data`.
- frame_err  output  1  one-cycle pulse: stop bit sampled low.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, data=8'h00, rx_valid=0, frame_err=0, busy=0, counters/bit index=0, synchroniser flops=1.
- Synchroniser: 2-flop on rx producing rx_s; all decisions use rx_s only. This adds 2 clk of latency.
- Counter width: $clog2(BAUD_WIDTH); never exceeds BAUD_WIDTH-1. Bit index is 3 bits.
- States are one-hot: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- IDLE: when rx_s==0, go to START and clear the counter. Otherwise stay.
- START:
  - Count up. At counter==HALF_WIDTH-1, sample rx_s.
  - If rx_s==1 (glitch), return to IDLE with no outputs.
  - Else clear the counter and go to DATA with bit index=0.
- DATA:
  - Count up. At counter==BAUD_WIDTH-1 (bit centre), shift rx_s into the shift register MSB, shifting right, so bit0 ends in LSB.
  - Clear the counter. If bit index==7, go to STOP; else increment the index.
- STOP: count up. At counter==BAUD_WIDTH-1, sample rx_s, then return to IDLE at mid-stop-bit so back-to-back frames are not missed.
  - rx_s==1: data<=shift register; rx_valid=1 for exactly one cycle, on the cycle after the sample.
  - rx_s==0: frame_err=1 for one cycle; data unchanged; rx_valid stays 0.
- Latency: rx_valid asserts 2 + HALF_WIDTH + 9*BAUD_WIDTH clk after the rx falling edge (±1 for sampling-phase alignment; 4125 at defaults).
- rx_valid and frame_err are never high in the same cycle.
- Line held low (break): frame_err fires once. After that, IDLE does not re-arm until rx_s has been seen high at least one cycle.
- Reset mid-frame aborts immediately. The partial byte is discarded; no strobes.
- No backpressure: the consumer must take data on rx_valid. data is stable until the next successful frame.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - Frame becomes 8E1. A PARITY state is inserted between DATA and STOP and samples one bit at counter==BAUD_WIDTH-1.
  - Adds output `parity_err` (1 bit, reset 0). It is a one-cycle pulse at the STOP sample when XOR(data bits, parity bit)!=0.
  - On parity error, data is not updated and rx_valid stays 0. If the stop bit is also low, frame_err and parity_err pulse together.
  - Latency grows by BAUD_WIDTH.
- Undefined: no PARITY state and no parity_err port; 8N1 exactly as above.

Test Plan:
- Reset, then send 0xA5 at 434 clk/bit -> one rx_valid pulse, data=8'hA5, frame_err never high, busy falls the cycle after the stop sample.
- Drive rx low for 100 clk, then high -> busy pulses, no rx_valid or frame_err, back to IDLE; a following 0x3C frame is received correctly.
- Send 0x3C with stop bit forced 0 (previous data 0xA5) -> frame_err pulses once, data stays 8'hA5, no rx_valid.
- Send 0x00 and 0xFF back-to-back with no idle gap beyond one stop bit -> two rx_valid pulses 4340 clk apart, data 8'h00 then 8'hFF.
- Assert rst_n=0 at bit 4 of a 0x55 frame, release, then send 0x81 -> no strobe for 0x55; data=8'h81 with one rx_valid.
- UART_RX_PARITY_EN: send 0x07 with parity bit 1 (correct, even) -> rx_valid, data=8'h07. Send again with parity bit 0 -> parity_err pulse, data unchanged, no rx_valid.
